// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: offset selector encoding and decode defaults.
package lc3b_types;

   typedef enum logic [1:0] {
      OFF6      = 2'd0,
      OFF9      = 2'd1,
      OFF11     = 2'd2,
      OFF6_BYTE = 2'd3
   } id_off_sel_t;

   localparam int unsigned TRAP_REG_DEFAULT = 7;
   localparam int unsigned WIDTH_DEFAULT    = 16;
   localparam int unsigned NREGS_DEFAULT    = 8;
   localparam int unsigned PEND_W_DEFAULT   = 2;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: IF/ID input handshake, ID/EX slot, flush and writeback port.
interface id_stage_pipe_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned RW    = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [RW-1:0]    in_sr1;
   logic [RW-1:0]    in_sr2;
   logic [RW-1:0]    in_dest;
   logic             in_sr1_used;
   logic             in_imm_sel;
   logic [4:0]       in_imm5;
   logic [10:0]      in_offset;
   logic [1:0]       in_off_sel;
   logic             in_trap;
   logic             in_writes;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_src1;
   logic [WIDTH-1:0] out_src2;
   logic [WIDTH-1:0] out_offset;
   logic [RW-1:0]    out_dest;
   logic             out_writes;

   logic             flush;

   logic             wb_valid;
   logic             wb_load;
   logic [RW-1:0]    wb_dest;
   logic [WIDTH-1:0] wb_data;

   // Upstream/downstream/writeback side of the decode stage.
   modport master (
      output in_valid, in_sr1, in_sr2, in_dest, in_sr1_used, in_imm_sel,
             in_imm5, in_offset, in_off_sel, in_trap, in_writes,
             out_ready, flush, wb_valid, wb_load, wb_dest, wb_data,
      input  in_ready, out_valid, out_src1, out_src2, out_offset, out_dest,
             out_writes
   );

   // The decode stage itself.
   modport slave (
      input  in_valid, in_sr1, in_sr2, in_dest, in_sr1_used, in_imm_sel,
             in_imm5, in_offset, in_off_sel, in_trap, in_writes,
             out_ready, flush, wb_valid, wb_load, wb_dest, wb_data,
      output in_ready, out_valid, out_src1, out_src2, out_offset, out_dest,
             out_writes
   );

endinterface

// File: rtl/id_scoreboard.sv
// Per-register pending-write counters and the RAW / saturation hazard they imply.
module id_scoreboard #(
   parameter  int unsigned NREGS  = 8,
   parameter  int unsigned PEND_W = 2,
   localparam int unsigned RW     = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic [RW-1:0] inc_idx,
   input  logic          dec_a,
   input  logic [RW-1:0] dec_a_idx,
   input  logic          dec_b,
   input  logic [RW-1:0] dec_b_idx,
   input  logic [RW-1:0] sr1,
   input  logic          sr1_used,
   input  logic [RW-1:0] sr2,
   input  logic          sr2_used,
   input  logic [RW-1:0] dest,
   input  logic          dest_used,
   input  logic          byp_valid,
   input  logic [RW-1:0] byp_idx,
   output logic          hazard_c
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [PEND_W-1:0] pend_q [NREGS];
   logic [PEND_W-1:0] pend_d [NREGS];
   logic [PEND_W:0]   up_c   [NREGS];
   logic [PEND_W:0]   dn_c   [NREGS];
   logic              unf_c  [NREGS];

   logic [PEND_W-1:0] p1_c, p2_c;
   logic              blk1_c, blk2_c, sat_c;

   // Net counter update: one possible increment, up to two decrements.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         up_c[r]   = {1'b0, pend_q[r]} + (PEND_W+1)'(inc && (inc_idx == RW'(r)));
         dn_c[r]   = (PEND_W+1)'(dec_a && (dec_a_idx == RW'(r)))
                   + (PEND_W+1)'(dec_b && (dec_b_idx == RW'(r)));
         unf_c[r]  = dn_c[r] > up_c[r];
         pend_d[r] = PEND_W'(up_c[r] - dn_c[r]);
      end
   end

   // Counter registers, plus a check that no retire/cancel outruns its issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            assert (!unf_c[r]) else $error("scoreboard underflow on r%0d", r);
            pend_q[r] <= pend_d[r];
         end
      end
   end

   // A pending source blocks unless its single outstanding write lands this cycle.
   always_comb begin
      p1_c     = pend_q[sr1];
      p2_c     = pend_q[sr2];
      blk1_c   = sr1_used && ((p1_c > PEND_ONE) ||
                 ((p1_c == PEND_ONE) && !(byp_valid && (byp_idx == sr1))));
      blk2_c   = sr2_used && ((p2_c > PEND_ONE) ||
                 ((p2_c == PEND_ONE) && !(byp_valid && (byp_idx == sr2))));
      // Destination check only matters for writers: it guards counter overflow.
      sat_c    = dest_used && (pend_q[dest] == PEND_MAX);
      hazard_c = blk1_c || blk2_c || sat_c;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// LC-3b decode stage: bypassed regfile, scoreboard stalls, offset/imm generation, ID/EX slot.
module id_stage_pipe
   import lc3b_types::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEFAULT,
   parameter int unsigned NREGS    = NREGS_DEFAULT,
   parameter int unsigned TRAP_REG = TRAP_REG_DEFAULT,
   parameter int unsigned PEND_W   = PEND_W_DEFAULT
) (
   input logic          clk,
   input logic          reset,
   id_stage_pipe_if.slave bus
);

   localparam int unsigned RW = $clog2(NREGS);

   logic [WIDTH-1:0] rf_q [NREGS];
   logic [WIDTH-1:0] rf_d [NREGS];

   logic             out_valid_q,  out_valid_d;
   logic             out_writes_q, out_writes_d;
   logic [WIDTH-1:0] out_src1_q,   out_src1_d;
   logic [WIDTH-1:0] out_src2_q,   out_src2_d;
   logic [WIDTH-1:0] out_offset_q, out_offset_d;
   logic [RW-1:0]    out_dest_q,   out_dest_d;

   logic             wb_wr_c;
   logic             hazard_c;
   logic             in_ready_c;
   logic             issue_c;
   logic             flush_kill_c;
   logic [RW-1:0]    dest_c;
   logic [WIDTH-1:0] src1_c, src2_c, offset_c;
   logic [WIDTH-1:0] imm_sx_c, off6_sx_c, off9_sx_c, off11_sx_c;
   id_off_sel_t      off_sel_c;

   assign wb_wr_c = bus.wb_valid && bus.wb_load;

   // Regfile write from the writeback stage.
   always_comb begin
      rf_d = rf_q;
      if (wb_wr_c) rf_d[bus.wb_dest] = bus.wb_data;
   end

   // Regfile storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
      end else begin
         rf_q <= rf_d;
      end
   end

   // Operand read with same-cycle writeback bypass, plus immediate/offset sign extension.
   always_comb begin
      imm_sx_c   = {{(WIDTH-5){bus.in_imm5[4]}},    bus.in_imm5};
      off6_sx_c  = {{(WIDTH-6){bus.in_offset[5]}},  bus.in_offset[5:0]};
      off9_sx_c  = {{(WIDTH-9){bus.in_offset[8]}},  bus.in_offset[8:0]};
      off11_sx_c = {{(WIDTH-11){bus.in_offset[10]}}, bus.in_offset[10:0]};

      src1_c = (wb_wr_c && (bus.wb_dest == bus.in_sr1)) ? bus.wb_data : rf_q[bus.in_sr1];
      if (bus.in_imm_sel)
         src2_c = imm_sx_c;
      else if (wb_wr_c && (bus.wb_dest == bus.in_sr2))
         src2_c = bus.wb_data;
      else
         src2_c = rf_q[bus.in_sr2];

      off_sel_c = id_off_sel_t'(bus.in_off_sel);
      case (off_sel_c)
         OFF6:      offset_c = {off6_sx_c[WIDTH-2:0],  1'b0};
         OFF9:      offset_c = {off9_sx_c[WIDTH-2:0],  1'b0};
         OFF11:     offset_c = {off11_sx_c[WIDTH-2:0], 1'b0};
         OFF6_BYTE: offset_c = off6_sx_c;
         default:   offset_c = off6_sx_c;
      endcase

      dest_c = bus.in_trap ? RW'(TRAP_REG) : bus.in_dest;
   end

   id_scoreboard #(
      .NREGS  (NREGS),
      .PEND_W (PEND_W)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .inc       (issue_c && bus.in_writes),
      .inc_idx   (dest_c),
      .dec_a     (bus.wb_valid),
      .dec_a_idx (bus.wb_dest),
      .dec_b     (flush_kill_c),
      .dec_b_idx (out_dest_q),
      .sr1       (bus.in_sr1),
      .sr1_used  (bus.in_sr1_used),
      .sr2       (bus.in_sr2),
      .sr2_used  (!bus.in_imm_sel),
      .dest      (dest_c),
      .dest_used (bus.in_writes),
      .byp_valid (wb_wr_c),
      .byp_idx   (bus.wb_dest),
      .hazard_c  (hazard_c)
   );

   // Handshake: accept when hazard-free, not flushing, and the slot is free or draining.
   always_comb begin
      in_ready_c   = !hazard_c && !bus.flush && (!out_valid_q || bus.out_ready);
      issue_c      = bus.in_valid && in_ready_c;
      flush_kill_c = bus.flush && out_valid_q && out_writes_q;
   end

   // ID/EX slot next state; flush wins over issue and drain.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_writes_d = out_writes_q;
      out_src1_d   = out_src1_q;
      out_src2_d   = out_src2_q;
      out_offset_d = out_offset_q;
      out_dest_d   = out_dest_q;
      if (bus.flush) begin
         out_valid_d  = 1'b0;
         out_writes_d = 1'b0;
      end else if (issue_c) begin
         out_valid_d  = 1'b1;
         out_writes_d = bus.in_writes;
         out_src1_d   = src1_c;
         out_src2_d   = src2_c;
         out_offset_d = offset_c;
         out_dest_d   = dest_c;
      end else if (bus.out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   // ID/EX slot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_writes_q <= 1'b0;
         out_src1_q   <= '0;
         out_src2_q   <= '0;
         out_offset_q <= '0;
         out_dest_q   <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_writes_q <= out_writes_d;
         out_src1_q   <= out_src1_d;
         out_src2_q   <= out_src2_d;
         out_offset_q <= out_offset_d;
         out_dest_q   <= out_dest_d;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_writes = out_writes_q;
   assign bus.out_src1   = out_src1_q;
   assign bus.out_src2   = out_src2_q;
   assign bus.out_offset = out_offset_q;
   assign bus.out_dest   = out_dest_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: issue, RAW stall/bypass, saturation, backpressure, flush, trap, offsets.
module tb_id_stage_pipe;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   id_stage_pipe_if #(.WIDTH(16), .RW(3)) bus_if ();

   id_stage_pipe #(
      .WIDTH    (16),
      .NREGS    (8),
      .TRAP_REG (7),
      .PEND_W   (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus_if.in_valid    = 1'b0;
      bus_if.in_sr1      = '0;
      bus_if.in_sr2      = '0;
      bus_if.in_dest     = '0;
      bus_if.in_sr1_used = 1'b0;
      bus_if.in_imm_sel  = 1'b0;
      bus_if.in_imm5     = '0;
      bus_if.in_offset   = '0;
      bus_if.in_off_sel  = '0;
      bus_if.in_trap     = 1'b0;
      bus_if.in_writes   = 1'b0;
      bus_if.out_ready   = 1'b0;
      bus_if.flush       = 1'b0;
      bus_if.wb_valid    = 1'b0;
      bus_if.wb_load     = 1'b0;
      bus_if.wb_dest     = '0;
      bus_if.wb_data     = '0;
   endtask

   task automatic put(input logic [2:0] sr1, input logic sr1u, input logic [2:0] sr2,
                      input logic imm_sel, input logic [4:0] imm5, input logic [2:0] dest,
                      input logic writes, input logic trap, input logic [1:0] sel,
                      input logic [10:0] off);
      bus_if.in_valid    = 1'b1;
      bus_if.in_sr1      = sr1;
      bus_if.in_sr1_used = sr1u;
      bus_if.in_sr2      = sr2;
      bus_if.in_imm_sel  = imm_sel;
      bus_if.in_imm5     = imm5;
      bus_if.in_dest     = dest;
      bus_if.in_writes   = writes;
      bus_if.in_trap     = trap;
      bus_if.in_off_sel  = sel;
      bus_if.in_offset   = off;
   endtask

   task automatic wb(input logic v, input logic ld, input logic [2:0] d, input logic [15:0] data);
      bus_if.wb_valid = v;
      bus_if.wb_load  = ld;
      bus_if.wb_dest  = d;
      bus_if.wb_data  = data;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      idle();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_valid",  bus_if.out_valid,  0);
      chk("rst_writes", bus_if.out_writes, 0);
      chk("rst_dest",   bus_if.out_dest,   0);
      chk("rst_src1",   bus_if.out_src1,   0);
      chk("rst_ready",  bus_if.in_ready,   1);

      // Writer to R3 so the following writeback has a matching pending entry.
      put(3'd0, 1'b0, 3'd0, 1'b1, 5'd0, 3'd3, 1'b1, 1'b0, 2'd0, 11'd0);
      bus_if.out_ready = 1'b1;
      #1 chk("a_ready", bus_if.in_ready, 1);
      cyc();
      chk("a_valid", bus_if.out_valid, 1);
      chk("a_dest",  bus_if.out_dest,  3);
      chk("a_wr",    bus_if.out_writes, 1);

      bus_if.in_valid = 1'b0;
      wb(1'b1, 1'b1, 3'd3, 16'h1234);
      cyc();
      wb(1'b0, 1'b0, 3'd0, 16'h0);
      chk("b_drain", bus_if.out_valid, 0);

      // Basic issue: R3 + sext(imm5=-1).
      put(3'd3, 1'b1, 3'd0, 1'b1, 5'h1F, 3'd0, 1'b0, 1'b0, 2'd0, 11'd0);
      #1 chk("c_ready", bus_if.in_ready, 1);
      cyc();
      chk("c_valid", bus_if.out_valid, 1);
      chk("c_src1",  bus_if.out_src1, 16'h1234);
      chk("c_src2",  bus_if.out_src2, 16'hFFFF);
      chk("c_wr",    bus_if.out_writes, 0);

      // RAW stall on R2, released by bypassed writeback.
      put(3'd0, 1'b0, 3'd0, 1'b1, 5'd0, 3'd2, 1'b1, 1'b0, 2'd0, 11'd0);
      cyc();
      put(3'd2, 1'b1, 3'd0, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 11'd0);
      #1 chk("raw_stall0", bus_if.in_ready, 0);
      cyc();
      chk("raw_empty", bus_if.out_valid, 0);
      #1 chk("raw_stall1", bus_if.in_ready, 0);
      cyc();
      wb(1'b1, 1'b1, 3'd2, 16'hBEEF);
      #1 chk("raw_release", bus_if.in_ready, 1);
      cyc();
      wb(1'b0, 1'b0, 3'd0, 16'h0);
      chk("raw_valid", bus_if.out_valid, 1);
      chk("raw_byp",   bus_if.out_src1, 16'hBEEF);

      // Saturation: three writers to R1 fill the counter.
      put(3'd0, 1'b0, 3'd0, 1'b1, 5'd0, 3'd1, 1'b1, 1'b0, 2'd0, 11'd0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("sat_fill", bus_if.in_ready, 1);
         cyc();
      end
      #1 chk("sat_stall", bus_if.in_ready, 0);
      cyc();
      chk("sat_empty", bus_if.out_valid, 0);
      wb(1'b1, 1'b0, 3'd1, 16'h0);
      #1 chk("sat_wb_cycle", bus_if.in_ready, 0);
      cyc();
      wb(1'b0, 1'b0, 3'd0, 16'h0);
      #1 chk("sat_release", bus_if.in_ready, 1);
      cyc();
      chk("sat_valid", bus_if.out_valid, 1);
      chk("sat_dest",  bus_if.out_dest, 1);
      #1 chk("sat_again", bus_if.in_ready, 0);
      bus_if.in_valid = 1'b0;
      cyc();

      // Backpressure: slot loaded, then held for three cycles.
      put(3'd3, 1'b1, 3'd2, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 2'd1, 11'h100);
      #1 chk("bp_ready0", bus_if.in_ready, 1);
      cyc();
      chk("bp_src1", bus_if.out_src1,   16'h1234);
      chk("bp_src2", bus_if.out_src2,   16'hBEEF);
      chk("bp_off9", bus_if.out_offset, 16'hFE00);
      bus_if.out_ready = 1'b0;
      put(3'd2, 1'b1, 3'd0, 1'b1, 5'h01, 3'd0, 1'b0, 1'b0, 2'd0, 11'd0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_stall", bus_if.in_ready, 0);
         cyc();
         chk("bp_hold_v",  bus_if.out_valid,  1);
         chk("bp_hold_s1", bus_if.out_src1,   16'h1234);
         chk("bp_hold_s2", bus_if.out_src2,   16'hBEEF);
         chk("bp_hold_of", bus_if.out_offset, 16'hFE00);
      end
      bus_if.out_ready = 1'b1;
      #1 chk("bp_resume", bus_if.in_ready, 1);
      cyc();
      chk("bp_new_s1",  bus_if.out_src1,   16'hBEEF);
      chk("bp_new_s2",  bus_if.out_src2,   16'h0001);
      chk("bp_new_off", bus_if.out_offset, 16'h0000);

      // Flush: slot holds writer to R5, incoming writer to R6 is discarded.
      put(3'd0, 1'b0, 3'd0, 1'b1, 5'd0, 3'd5, 1'b1, 1'b0, 2'd0, 11'd0);
      cyc();
      chk("fl_loaded", bus_if.out_dest, 5);
      put(3'd0, 1'b0, 3'd0, 1'b1, 5'd0, 3'd6, 1'b1, 1'b0, 2'd0, 11'd0);
      bus_if.flush     = 1'b1;
      bus_if.out_ready = 1'b0;
      #1 chk("fl_ready", bus_if.in_ready, 0);
      cyc();
      bus_if.flush = 1'b0;
      chk("fl_valid", bus_if.out_valid, 0);
      put(3'd5, 1'b1, 3'd6, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 11'h020);
      bus_if.out_ready = 1'b1;
      #1 chk("fl_pend_clear", bus_if.in_ready, 1);
      cyc();
      chk("fl_reissue", bus_if.out_valid,  1);
      chk("fl_src1",    bus_if.out_src1,   16'h0000);
      chk("off6_shift", bus_if.out_offset, 16'hFFC0);

      // Trap destination and offset generators.
      put(3'd0, 1'b0, 3'd0, 1'b1, 5'd0, 3'd2, 1'b1, 1'b1, 2'd2, 11'h400);
      #1 chk("trap_ready", bus_if.in_ready, 1);
      cyc();
      chk("trap_dest", bus_if.out_dest,   7);
      chk("off11",     bus_if.out_offset, 16'hF800);
      put(3'd7, 1'b1, 3'd0, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0, 2'd3, 11'h03F);
      #1 chk("trap_pend7", bus_if.in_ready, 0);
      cyc();
      wb(1'b1, 1'b1, 3'd7, 16'h00AA);
      #1 chk("trap_release", bus_if.in_ready, 1);
      cyc();
      wb(1'b0, 1'b0, 3'd0, 16'h0);
      chk("trap_byp",  bus_if.out_src1,   16'h00AA);
      chk("off6_byte", bus_if.out_offset, 16'hFFFF);
      put(3'd2, 1'b1, 3'd0, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 11'd0);
      #1 chk("trap_no_r2", bus_if.in_ready, 1);
      bus_if.in_valid = 1'b0;
      cyc();

      // Mid-run reset clears slot, scoreboard and regfile.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst2_valid", bus_if.out_valid,  0);
      chk("rst2_dest",  bus_if.out_dest,   0);
      chk("rst2_off",   bus_if.out_offset, 0);
      put(3'd1, 1'b1, 3'd3, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 11'd0);
      #1 chk("rst2_pend", bus_if.in_ready, 1);
      cyc();
      chk("rst2_src1", bus_if.out_src1, 0);
      chk("rst2_src2", bus_if.out_src2, 0);
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the LC-3b pipeline.
- Integrates the register file with write-to-read bypass, a per-register pending-write scoreboard that generates load-use/RAW stalls, and the offset/immediate generators.
- Ends in a registered ID/EX pipeline slot with a valid/ready handshake and flush.
- Sits between the IF/ID register and the execute stage; the writeback stage drives the wb_* ports.

Parameters:
- WIDTH, 16, datapath word width.
- NREGS, 8, number of architectural registers (power of two); register index width RW = log2(NREGS).
- TRAP_REG, 7, destination forced when in_trap=1.
- PEND_W, 2, width of each scoreboard counter; allows up to 2^PEND_W-1 outstanding writes per register.

Ports:
- clk in 1: clock, all state rises on posedge.
- reset in 1: synchronous, active-high.
- in_valid in 1: decoded instruction present.
- in_ready out 1: ID accepts the instruction this cycle.
- in_sr1 in RW: source 1 index.
- in_sr2 in RW: source 2 index.
- in_dest in RW: destination index.
- in_sr1_used in 1: sr1 is read by the instruction.
- in_imm_sel in 1: 1 selects sign-extended imm5 for src2, and sr2 is then not a dependency.
- in_imm5 in 5: immediate field.
- in_offset in 11: raw offset field; low bits are used per in_off_sel.
- in_off_sel in 2: 0=sext(off6)<<1, 1=sext(off9)<<1, 2=sext(off11)<<1, 3=sext(off6) unshifted (byte access).
- in_trap in 1: force dest to TRAP_REG.
- in_writes in 1: instruction writes a register.
- out_valid out 1: ID/EX slot holds a valid instruction.
- out_ready in 1: execute consumes the slot.
- out_src1 out WIDTH: source 1 operand.
- out_src2 out WIDTH: source 2 operand.
- out_offset out WIDTH: selected offset.
- out_dest out RW: final destination.
- out_writes out 1: slot instruction writes a register.
- flush in 1: kill the slot contents and the incoming instruction.
- wb_valid in 1: a register-writing instruction retires (or is squashed) this cycle.
- wb_load in 1: perform the regfile write (qualified by wb_valid).
- wb_dest in RW: retiring destination.
- wb_data in WIDTH: write data.

Behaviour:
- Reset: all registers, all scoreboard counters, out_valid, out_writes, out_src1/out_src2/out_offset/out_dest become 0 on the first clk edge with reset=1.
- Regfile: written at posedge when wb_valid&&wb_load.
- Reads are combinational, with bypass: if wb_valid&&wb_load&&wb_dest==sr, the read returns wb_data.
- Scoreboard: pend[r] counter.
  - Increment when an instruction with in_writes=1 is issued into the slot; the final dest is used (TRAP_REG if in_trap).
  - Decrement on wb_valid for wb_dest, whether wb_load is 0 or 1.
  - Decrement when flush kills a valid slot with out_writes=1 (index out_dest).
  - Simultaneous increment and decrement on the same register: no change.
  - Two decrements on the same register in one cycle: net -2.
  - Never underflow; underflow is an assertion failure.
- Hazard: a source is blocked if it is used and one of these holds:
  - pend>=2, or
  - pend==1 and it is not bypassed this cycle (bypass requires wb_valid&&wb_load&&wb_dest==src).
  - sr2 counts as used only when in_imm_sel=0.
- Also stall when the final dest has pend == 2^PEND_W-1 (saturated).
- Issue condition: in_valid && !hazard && !flush && (!out_valid || out_ready). in_ready = !hazard && !flush && (!out_valid || out_ready).
- Slot update at posedge:
  - On issue: load operands/offset/dest/writes, out_valid=1.
  - On out_ready without issue: out_valid=0.
  - Otherwise hold all outputs stable while out_valid && !out_ready.
- flush has priority: out_valid=0 next cycle, nothing is issued, and a flushed slot's pending write is cancelled as above.
- reset has priority over flush.
- Latency: one cycle from issue to out_valid.
- Offsets: sign-extend then shift to WIDTH bits, with the shift dropping the MSB.
- Arithmetic: no carries, widths exact.

Decomposition:
- Shared package lc3b_types gains:
  - id_off_sel_t enum (OFF6, OFF9, OFF11, OFF6_BYTE).
  - TRAP_REG_DEFAULT.
- One sub-module, id_scoreboard, holds the pend counters, the increment/decrement logic and the hazard outputs.
- The regfile and the offset generation stay inline.

Test Plan:
- Basic issue:
  - Stimulus: after reset, wb write R3=0x1234; next cycle issue ADD sr1=3, imm5=5'b11111, in_imm_sel=1, out_ready=1.
  - Response: out_src1=0x1234, out_src2=0xFFFF, out_valid one cycle later.
- RAW stall:
  - Stimulus: issue a writer to R2; next instruction reads sr1=2.
  - Response: in_ready=0 while pend[2]=1.
  - Release: wb_valid/wb_load R2=0xBEEF.
  - Required: same cycle in_ready=1 and out_src1=0xBEEF via bypass.
- Saturation:
  - Stimulus: three writers to R1 with no writeback (PEND_W=2).
  - Response: fourth writer stalls; one wb_valid with wb_load=0 to R1 releases it, with pend staying at 3.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with slot valid.
  - Response: outputs constant, in_ready=0; issue resumes the cycle out_ready=1.
- Flush:
  - Stimulus: slot holds writer to R5 (pend[5]=1); flush=1 together with in_valid=1.
  - Response: out_valid=0 next cycle, pend[5]=0, nothing issued.
- Trap and offsets:
  - Stimulus: in_trap=1, in_dest=2.
  - Response: out_dest=7, pend[7] increments.
  - Stimulus: offset11=11'h400, sel=2.
  - Response: out_offset=0xF800.
  - Stimulus: off6=6'h3F, sel=3.
  - Response: out_offset=0xFFFF.
